// File: rtl/jal_issue_buffer_pkg.sv
// Shared sizing and entry layout for the JAL/JALR issue buffer.
// Entry packing {jal, jalr, pc, rd0, rs1, is_rvc} matches the issue-stage unpack.
package jal_issue_buffer_pkg;

  localparam int unsigned RB   = 2;
  localparam int unsigned RW   = 5 + RB;
  localparam int unsigned DW   = 2 + 64 + 2 * RW + 1;
  localparam int unsigned DP   = 4;
  localparam int unsigned IW   = $clog2(DP);
  localparam int unsigned CNTW = IW + 1;

  typedef struct packed {
    logic          jal;
    logic          jalr;
    logic [63:0]   pc;
    logic [RW-1:0] rd0;
    logic [RW-1:0] rs1;
    logic          is_rvc;
  } jal_info_t;

  // Number of allocated slots in a valid vector.
  function automatic logic [CNTW-1:0] slot_count(input logic [DP-1:0] vld);
    logic [CNTW-1:0] c;
    c = '0;
    for (int i = 0; i < int'(DP); i++) begin
      c = c + CNTW'(vld[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/jal_issue_buffer_lzp.sv
// Lowest-zero-position finder: index of the lowest clear bit of vec.
// none_free is set when every bit of vec is set.
module jal_issue_buffer_lzp #(
  parameter int unsigned CW = 2
) (
  input  logic [(1<<CW)-1:0] vec,
  output logic [CW-1:0]      idx,
  output logic               none_free
);

  localparam int unsigned N = 1 << CW;

  // Scan high to low so the lowest clear bit wins.
  always_comb begin
    idx       = '0;
    none_free = 1'b1;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (!vec[i]) begin
        idx       = CW'(i);
        none_free = 1'b0;
      end
    end
  end

endmodule

// File: rtl/jal_issue_buffer.sv
// Write side of the JAL/JALR issue buffer: allocates dispatch entries into
// free slots, frees slots on issue pop, bulk-invalidates on flush.
module jal_issue_buffer
  import jal_issue_buffer_pkg::*;
(
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               jal_dispat_push,
  input  logic [DW-1:0]      jal_dispat_info,
  output logic               jal_buffer_full,
  output logic               jal_buffer_empty,
  output logic [CNTW-1:0]    jal_buffer_cnt,
  input  logic               jal_buffer_pop,
  input  logic [IW-1:0]      jal_buffer_pop_index,
  output logic [DP-1:0]      jal_buffer_malloc,
  output logic [DW*DP-1:0]   jal_issue_info,
  input  logic               flush
);

  logic [DP-1:0] malloc;
  logic [DP-1:0] malloc_nxt;
  jal_info_t     payload [DP];
  logic [IW-1:0] free_idx;
  logic          none_free;
  logic          push_acc;
  logic          pop_acc;

  jal_issue_buffer_lzp #(.CW(IW)) u_lzp (
    .vec       (malloc),
    .idx       (free_idx),
    .none_free (none_free)
  );

  // Full is judged on the registered state, so a same-cycle pop cannot make room.
  assign push_acc = jal_dispat_push & ~none_free & ~flush;
  assign pop_acc  = jal_buffer_pop & malloc[jal_buffer_pop_index] & ~flush;

  always_comb begin
    malloc_nxt = malloc;
    if (flush) begin
      malloc_nxt = '0;
    end else begin
      if (pop_acc)  malloc_nxt[jal_buffer_pop_index] = 1'b0;
      if (push_acc) malloc_nxt[free_idx]             = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) malloc <= '0;
    else       malloc <= malloc_nxt;
  end

  // Payload is written only on accepted push; pop and flush leave it stale.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < int'(DP); i++) payload[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DP); i++) begin
        if (push_acc && (free_idx == IW'(i))) payload[i] <= jal_info_t'(jal_dispat_info);
      end
    end
  end

  for (genvar g = 0; g < int'(DP); g++) begin : g_info
    assign jal_issue_info[DW*g +: DW] = payload[g];
  end

  assign jal_buffer_malloc = malloc;
  assign jal_buffer_full   = none_free;
  assign jal_buffer_empty  = ~|malloc;
  assign jal_buffer_cnt    = slot_count(malloc);

  // Popping a slot that holds no entry is a protocol violation by the issue stage.
  always @(posedge CLK) begin
    if (RSTn && jal_buffer_pop && !flush) begin
      assert (malloc[jal_buffer_pop_index])
        else $warning("jal_issue_buffer: pop of unallocated slot %0d", jal_buffer_pop_index);
    end
  end

endmodule

// File: tb/tb_jal_issue_buffer.sv
// Directed bench for jal_issue_buffer: allocation order, full/pop/flush
// interaction and asynchronous reset.
module tb_jal_issue_buffer;

  localparam int DW     = 81;
  localparam int DP     = 4;
  localparam int PC_LSB = 15;

  logic            CLK;
  logic            RSTn;
  logic            jal_dispat_push;
  logic [DW-1:0]   jal_dispat_info;
  logic            jal_buffer_full;
  logic            jal_buffer_empty;
  logic [2:0]      jal_buffer_cnt;
  logic            jal_buffer_pop;
  logic [1:0]      jal_buffer_pop_index;
  logic [DP-1:0]   jal_buffer_malloc;
  logic [DW*DP-1:0] jal_issue_info;
  logic            flush;

  int tests;
  int fails;

  jal_issue_buffer dut (
    .CLK                  (CLK),
    .RSTn                 (RSTn),
    .jal_dispat_push      (jal_dispat_push),
    .jal_dispat_info      (jal_dispat_info),
    .jal_buffer_full      (jal_buffer_full),
    .jal_buffer_empty     (jal_buffer_empty),
    .jal_buffer_cnt       (jal_buffer_cnt),
    .jal_buffer_pop       (jal_buffer_pop),
    .jal_buffer_pop_index (jal_buffer_pop_index),
    .jal_buffer_malloc    (jal_buffer_malloc),
    .jal_issue_info       (jal_issue_info),
    .flush                (flush)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // jal=1, jalr=0, pc, rd0=3, rs1=5, is_rvc=0
  function automatic logic [DW-1:0] mk(input logic [63:0] pc);
    return {1'b1, 1'b0, pc, 7'd3, 7'd5, 1'b0};
  endfunction

  function automatic logic [63:0] slot_pc(input logic [DW*DP-1:0] info, input int s);
    return info[DW*s + PC_LSB +: 64];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic push, input logic [63:0] pc, input logic pop,
                      input logic [1:0] pidx, input logic fl);
    jal_dispat_push      = push;
    jal_dispat_info      = mk(pc);
    jal_buffer_pop       = pop;
    jal_buffer_pop_index = pidx;
    flush                = fl;
    @(posedge CLK);
    #1;
    jal_dispat_push = 1'b0;
    jal_buffer_pop  = 1'b0;
    flush           = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    RSTn = 1'b0;
    jal_dispat_push = 1'b0;
    jal_dispat_info = '0;
    jal_buffer_pop = 1'b0;
    jal_buffer_pop_index = '0;
    flush = 1'b0;
    #3;
    check("rst_malloc", 64'(jal_buffer_malloc), 64'h0);
    check("rst_empty",  64'(jal_buffer_empty),  64'h1);
    check("rst_full",   64'(jal_buffer_full),   64'h0);
    check("rst_cnt",    64'(jal_buffer_cnt),    64'h0);
    check("rst_pc3",    slot_pc(jal_issue_info, 3), 64'h0);
    #9 RSTn = 1'b1;

    // Four back-to-back pushes fill slots in index order
    step(1, 64'h1000, 0, 0, 0); check("push0_malloc", 64'(jal_buffer_malloc), 64'h1);
    check("push0_empty", 64'(jal_buffer_empty), 64'h0);
    step(1, 64'h1004, 0, 0, 0); check("push1_malloc", 64'(jal_buffer_malloc), 64'h3);
    step(1, 64'h1008, 0, 0, 0); check("push2_malloc", 64'(jal_buffer_malloc), 64'h7);
    step(1, 64'h100C, 0, 0, 0); check("push3_malloc", 64'(jal_buffer_malloc), 64'hF);
    check("fill_full", 64'(jal_buffer_full), 64'h1);
    check("fill_cnt",  64'(jal_buffer_cnt),  64'h4);
    check("slot2_pc",  slot_pc(jal_issue_info, 2), 64'h1008);
    check("slot2_lo14", 64'(jal_issue_info[DW*2 +: 15]), 64'({7'd3, 7'd5, 1'b0}));

    // Push while full is ignored
    step(1, 64'h2000, 0, 0, 0);
    check("fullpush_malloc", 64'(jal_buffer_malloc), 64'hF);
    check("fullpush_slot0",  slot_pc(jal_issue_info, 0), 64'h1000);
    check("fullpush_full",   64'(jal_buffer_full), 64'h1);

    // Pop while full: pop applied, push rejected
    step(1, 64'h2000, 1, 2'd1, 0);
    check("popfull_malloc", 64'(jal_buffer_malloc), 64'hD);
    check("popfull_cnt",    64'(jal_buffer_cnt),    64'h3);
    check("popfull_stale1", slot_pc(jal_issue_info, 1), 64'h1004);
    step(1, 64'h2000, 0, 0, 0);
    check("refill_slot1",  slot_pc(jal_issue_info, 1), 64'h2000);
    check("refill_malloc", 64'(jal_buffer_malloc), 64'hF);

    // Reach 0101, then push + pop slot0 together: push goes to slot1
    step(0, 64'h0, 1, 2'd1, 0);
    step(0, 64'h0, 1, 2'd3, 0);
    check("m0101", 64'(jal_buffer_malloc), 64'h5);
    step(1, 64'h3000, 1, 2'd0, 0);
    check("pp_malloc", 64'(jal_buffer_malloc), 64'h6);
    check("pp_cnt",    64'(jal_buffer_cnt),    64'h2);
    check("pp_slot1",  slot_pc(jal_issue_info, 1), 64'h3000);
    check("pp_slot0",  slot_pc(jal_issue_info, 0), 64'h1000);

    // Refill, then flush beats simultaneous push and pop
    step(1, 64'h4000, 0, 0, 0);
    step(1, 64'h5000, 0, 0, 0);
    check("prefl_malloc", 64'(jal_buffer_malloc), 64'hF);
    step(1, 64'h6000, 1, 2'd2, 1);
    check("fl_malloc", 64'(jal_buffer_malloc), 64'h0);
    check("fl_empty",  64'(jal_buffer_empty),  64'h1);
    check("fl_cnt",    64'(jal_buffer_cnt),    64'h0);
    check("fl_slot0",  slot_pc(jal_issue_info, 0), 64'h4000);
    check("fl_slot1",  slot_pc(jal_issue_info, 1), 64'h3000);
    check("fl_slot2",  slot_pc(jal_issue_info, 2), 64'h1008);
    check("fl_slot3",  slot_pc(jal_issue_info, 3), 64'h5000);

    // Build 1010 and reset asynchronously between edges
    step(1, 64'hA000, 0, 0, 0);
    step(1, 64'hA004, 0, 0, 0);
    step(1, 64'hA008, 0, 0, 0);
    step(1, 64'hA00C, 0, 0, 0);
    step(0, 64'h0, 1, 2'd0, 0);
    step(0, 64'h0, 1, 2'd2, 0);
    check("m1010", 64'(jal_buffer_malloc), 64'hA);
    #2 RSTn = 1'b0;
    #1;
    check("arst_malloc", 64'(jal_buffer_malloc), 64'h0);
    check("arst_empty",  64'(jal_buffer_empty),  64'h1);
    check("arst_pc1",    slot_pc(jal_issue_info, 1), 64'h0);
    #2 RSTn = 1'b1;

    // Pop of an empty slot changes nothing
    step(0, 64'h0, 1, 2'd2, 0);
    check("badpop_malloc", 64'(jal_buffer_malloc), 64'h0);
    check("badpop_cnt",    64'(jal_buffer_cnt),    64'h0);
    step(1, 64'hB000, 0, 0, 0);
    check("post_malloc", 64'(jal_buffer_malloc), 64'h1);
    check("post_slot0",  slot_pc(jal_issue_info, 0), 64'hB000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
